avalon_packet_arbiter: RTL and testbench
========================================

# avalon_packet_arbiter

Packet-level round-robin arbiter that shares one downstream Avalon-ST channel between NUM_SRC upstream sources. Each source is the enforced output of an avalon_enforcer instance, so sop/valid/eop framing on the inputs is well-formed. A grant is held for a whole packet. A stall watchdog closes any packet whose source goes silent mid-packet, then flushes the rest of that source's packet so the shared channel cannot hang.

## Interface
Parameters:
- NUM_SRC, 4, number of upstream sources (2..16).
- TIMEOUT_CYCLES, 64, consecutive idle cycles inside a granted packet before forced close; 0 disables the watchdog.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  asynchronous, active-low reset.
- src  avalon_st_if.slave array  [NUM_SRC]  upstream sources (valid, rdy, sop, eop, data, empty).
- arb_out  avalon_st_if.master  1  shared downstream channel.
- grant_idx  output  $clog2(NUM_SRC)  index of the currently or last granted source.
- busy  output  1  high in SENDING or CLOSING.
- timeout_indc  output  1  one-cycle pulse when a packet is force-closed.

## Operation
- States: IDLE, SENDING, CLOSING. Registers: state, grant_idx, last_grant, stall_cnt (width $clog2(TIMEOUT_CYCLES+1)), flush[NUM_SRC].
- Request from source i: src[i].valid & src[i].sop & ~flush[i].
- IDLE:
  - All src[i].rdy = flush[i].
  - arb_out.valid = 0. arb_out.sop/eop/data/empty = 0.
  - If any request: grant_idx <= first requester searching last_grant+1, last_grant+2, ..., wrapping modulo NUM_SRC, with last_grant checked last. stall_cnt <= 0. Go to SENDING.
- SENDING, with g = grant_idx:
  - arb_out.valid/sop/eop/data/empty = src[g] fields. When valid is low, data/eop/empty/sop are driven 0.
  - src[g].rdy = arb_out.rdy. For every other i, src[i].rdy = flush[i].
  - On src[g].valid & arb_out.rdy & src[g].eop: last_grant <= g, go to IDLE.
  - stall_cnt clears when src[g].valid = 1, whether or not the beat is accepted. Downstream backpressure never counts as a stall.
  - stall_cnt increments when src[g].valid = 0.
  - If TIMEOUT_CYCLES != 0, src[g].valid = 0 and stall_cnt == TIMEOUT_CYCLES-1: go to CLOSING.
- CLOSING:
  - arb_out drives valid = 1, eop = 1, sop = 0, data = 0, empty = 0.
  - src[g].rdy = 0. Other sources follow their flush bits.
  - On arb_out.rdy: flush[g] <= 1, last_grant <= g, timeout_indc pulses for that cycle, go to IDLE.
- Flush handling:
  - While flush[i] is set, every src[i] beat is accepted and discarded, and source i is excluded from arbitration.
  - flush[i] clears on src[i].valid & src[i].eop, including a single-beat sop&eop packet.
  - A source that is flushing can be re-granted no earlier than the cycle after flush[i] clears.
- A source may hold valid&sop for any number of cycles without being granted. Losers see rdy = 0 and are never dropped.

## Timing
- Reset (rst low, asynchronous) sets:
  - state = IDLE, grant_idx = 0, last_grant = NUM_SRC-1 (so source 0 wins first), stall_cnt = 0, flush = 0.
  - Outputs: arb_out.valid/sop/eop/data/empty = 0, all src rdy = 0, busy = 0, timeout_indc = 0.
- Reset mid-packet abandons the packet with no closing beat. Downstream must tolerate this, as it already must for any other reset.
- Arbitration latency:
  - Request seen in cycle N, grant registered at the N+1 edge.
  - The first beat can be transferred in cycle N+1.
- Inter-packet gap: exactly one IDLE cycle after each accepted eop, so maximum throughput is L/(L+1) for L-beat packets.
- Timeout:
  - The close beat is presented TIMEOUT_CYCLES cycles after the last valid beat of the granted source.
  - timeout_indc asserts in the cycle the close beat is accepted.
- Simultaneous events:
  - Requests from several sources in the same cycle resolve strictly by round-robin order.
  - A source whose flush clears in cycle N is not a requester in cycle N.
  - src[g].valid rising in the same cycle stall_cnt hits its limit cancels the timeout.
- All state changes happen on posedge clk. Datapath muxing is combinational from registered grant_idx.

## Test plan
- Single source, 3-beat packet on src[0] with arb_out.rdy = 1: grant_idx = 0, busy rises one cycle after the request, 3 beats out unchanged with sop on beat 1 and eop on beat 3, then one IDLE cycle.
- NUM_SRC = 4, all four request continuously with 2-beat packets: grant order is 0, 1, 2, 3, 0, and no packets interleave.
- arb_out.rdy toggles 1/0 during a 5-beat src[2] packet with src[2].valid held high: all 5 beats pass, there is no timeout, and stall_cnt stays 0.
- TIMEOUT_CYCLES = 8, src[1] sends sop then drops valid: after 8 idle cycles arb_out shows valid = 1, eop = 1, data = 0, timeout_indc pulses, and flush[1] = 1. src[1]'s later 2 beats ending in eop are absorbed with rdy = 1 and nothing appears on arb_out.
- Flushing src[1] while src[3] requests: src[3] is granted immediately, and src[1] is re-granted only after its flush clears.
- rst asserted in SENDING mid-packet: all outputs go to 0 at once. After release, the next request from source 0 is granted first.

Source files
------------

// File: rtl/avalon_packet_arbiter.sv
// Packet-level round-robin arbiter sharing one Avalon-ST channel among NUM_SRC sources.
// A stall watchdog force-closes a silent packet and flushes the remainder of that source's packet.
module avalon_packet_arbiter #(
  parameter int NUM_SRC        = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int DATA_W         = 32,
  parameter int EMPTY_W        = 2,
  localparam int IDX_W         = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_SRC-1:0]         srcValid_i,
  output logic [NUM_SRC-1:0]         srcRdy_o,
  input  logic [NUM_SRC-1:0]         srcSop_i,
  input  logic [NUM_SRC-1:0]         srcEop_i,
  input  logic [NUM_SRC*DATA_W-1:0]  srcData_i,
  input  logic [NUM_SRC*EMPTY_W-1:0] srcEmpty_i,
  output logic                       outValid_o,
  input  logic                       outRdy_i,
  output logic                       outSop_o,
  output logic                       outEop_o,
  output logic [DATA_W-1:0]          outData_o,
  output logic [EMPTY_W-1:0]         outEmpty_o,
  output logic [IDX_W-1:0]           grantIdx_o,
  output logic                       busy_o,
  output logic                       timeoutIndc_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] STALL_LIMIT = WDOG_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE,
    SENDING,
    CLOSING
  } arbState_e;

  arbState_e           state_q, state_d;
  logic [IDX_W-1:0]    grantIdx_q, grantIdx_d;
  logic [IDX_W-1:0]    lastGrant_q, lastGrant_d;
  logic [CNT_W-1:0]    stallCnt_q, stallCnt_d;
  logic [NUM_SRC-1:0]  flush_q, flush_d;

  logic [NUM_SRC-1:0]  req;
  logic                anyReq;
  logic [IDX_W-1:0]    pick;

  logic                gValid;
  logic                gSop;
  logic                gEop;
  logic [DATA_W-1:0]   gData;
  logic [EMPTY_W-1:0]  gEmpty;

  assign req = srcValid_i & srcSop_i & ~flush_q;

  // Round-robin search starts just after the last grant, so last_grant itself is tried last.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] candIdx;
    anyReq  = 1'b0;
    pick    = '0;
    cand    = 0;
    candIdx = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand    = (int'(lastGrant_q) + k) % NUM_SRC;
      candIdx = IDX_W'(cand);
      if (!anyReq && req[candIdx]) begin
        anyReq = 1'b1;
        pick   = candIdx;
      end
    end
  end

  always_comb begin
    gValid = srcValid_i[grantIdx_q];
    gSop   = srcSop_i[grantIdx_q];
    gEop   = srcEop_i[grantIdx_q];
    gData  = srcData_i[int'(grantIdx_q)*DATA_W +: DATA_W];
    gEmpty = srcEmpty_i[int'(grantIdx_q)*EMPTY_W +: EMPTY_W];
  end

  always_comb begin
    state_d       = state_q;
    grantIdx_d    = grantIdx_q;
    lastGrant_d   = lastGrant_q;
    stallCnt_d    = stallCnt_q;
    flush_d       = flush_q & ~(srcValid_i & srcEop_i);
    srcRdy_o      = flush_q;
    outValid_o    = 1'b0;
    outSop_o      = 1'b0;
    outEop_o      = 1'b0;
    outData_o     = '0;
    outEmpty_o    = '0;
    timeoutIndc_o = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (anyReq) begin
          grantIdx_d = pick;
          stallCnt_d = '0;
          state_d    = SENDING;
        end
      end

      SENDING: begin
        srcRdy_o[grantIdx_q] = outRdy_i;
        outValid_o           = gValid;
        if (gValid) begin
          outSop_o   = gSop;
          outEop_o   = gEop;
          outData_o  = gData;
          outEmpty_o = gEmpty;
          stallCnt_d = '0;
          if (outRdy_i && gEop) begin
            lastGrant_d = grantIdx_q;
            state_d     = IDLE;
          end
        end else if (WDOG_EN) begin
          // Only a silent source counts as a stall; downstream backpressure never does.
          stallCnt_d = stallCnt_q + CNT_W'(1);
          if (stallCnt_q == STALL_LIMIT) begin
            state_d = CLOSING;
          end
        end
      end

      CLOSING: begin
        srcRdy_o[grantIdx_q] = 1'b0;
        outValid_o           = 1'b1;
        outEop_o             = 1'b1;
        if (outRdy_i) begin
          flush_d[grantIdx_q] = 1'b1;
          lastGrant_d         = grantIdx_q;
          timeoutIndc_o       = 1'b1;
          state_d             = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      grantIdx_q  <= '0;
      lastGrant_q <= IDX_W'(NUM_SRC - 1);
      stallCnt_q  <= '0;
      flush_q     <= '0;
    end else begin
      state_q     <= state_d;
      grantIdx_q  <= grantIdx_d;
      lastGrant_q <= lastGrant_d;
      stallCnt_q  <= stallCnt_d;
      flush_q     <= flush_d;
    end
  end

  assign grantIdx_o = grantIdx_q;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_avalon_packet_arbiter.sv
// Directed self-checking bench for avalon_packet_arbiter with four sources and an 8-cycle watchdog.
// Inputs change just after the rising edge; outputs are compared a few ns later.
module tb_avalon_packet_arbiter;

  localparam int NS = 4;
  localparam int DW = 32;
  localparam int EW = 2;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NS-1:0]   srcValid;
  logic [NS-1:0]   srcRdy;
  logic [NS-1:0]   srcSop;
  logic [NS-1:0]   srcEop;
  logic [NS*DW-1:0] srcData;
  logic [NS*EW-1:0] srcEmpty;
  logic            outValid;
  logic            outRdy;
  logic            outSop;
  logic            outEop;
  logic [DW-1:0]   outData;
  logic [EW-1:0]   outEmpty;
  logic [1:0]      grantIdx;
  logic            busy;
  logic            timeoutIndc;

  int vectors = 0;
  int miscompares = 0;

  avalon_packet_arbiter #(
    .NUM_SRC(NS),
    .TIMEOUT_CYCLES(TO),
    .DATA_W(DW),
    .EMPTY_W(EW)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .srcValid_i(srcValid),
    .srcRdy_o(srcRdy),
    .srcSop_i(srcSop),
    .srcEop_i(srcEop),
    .srcData_i(srcData),
    .srcEmpty_i(srcEmpty),
    .outValid_o(outValid),
    .outRdy_i(outRdy),
    .outSop_o(outSop),
    .outEop_o(outEop),
    .outData_o(outData),
    .outEmpty_o(outEmpty),
    .grantIdx_o(grantIdx),
    .busy_o(busy),
    .timeoutIndc_o(timeoutIndc)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int i, input logic v, input logic s, input logic e,
                               input logic [31:0] d, input logic [1:0] em);
    srcValid[i]          = v;
    srcSop[i]            = s;
    srcEop[i]            = e;
    srcData[i*DW +: DW]  = d;
    srcEmpty[i*EW +: EW] = em;
  endtask

  task automatic clearAll();
    srcValid = '0;
    srcSop   = '0;
    srcEop   = '0;
    srcData  = '0;
    srcEmpty = '0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    int beat [NS];
    int order [5];
    int pkt;
    int curSrc;
    int cyc;
    int b;

    rst_n  = 1'b1;
    outRdy = 1'b1;
    clearAll();
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'hDEAD, 2'd0);
    #1 rst_n = 1'b0;
    #12;
    checkOutput("reset outValid", outValid, 0);
    checkOutput("reset srcRdy", srcRdy, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset timeout", timeoutIndc, 0);
    checkOutput("reset grantIdx", grantIdx, 0);
    checkOutput("reset outData", outData, 0);
    @(negedge clk);
    clearAll();
    rst_n = 1'b1;

    // single 3-beat packet on source 0, then an immediate single-beat follow-up
    nextCycle();
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'hA0, 2'd0);
    settle();
    checkOutput("t1 idle busy", busy, 0);
    checkOutput("t1 idle outValid", outValid, 0);
    checkOutput("t1 idle srcRdy0", srcRdy[0], 0);
    nextCycle();
    checkOutput("t1 grant", grantIdx, 0);
    checkOutput("t1 busy", busy, 1);
    checkOutput("t1 b1 valid", outValid, 1);
    checkOutput("t1 b1 sop", outSop, 1);
    checkOutput("t1 b1 data", outData, 32'hA0);
    checkOutput("t1 b1 srcRdy0", srcRdy[0], 1);
    nextCycle();
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 32'hA1, 2'd0);
    settle();
    checkOutput("t1 b2 data", outData, 32'hA1);
    checkOutput("t1 b2 sop", outSop, 0);
    checkOutput("t1 b2 eop", outEop, 0);
    nextCycle();
    applyStimulus(0, 1'b1, 1'b0, 1'b1, 32'hA2, 2'd1);
    settle();
    checkOutput("t1 b3 eop", outEop, 1);
    checkOutput("t1 b3 data", outData, 32'hA2);
    checkOutput("t1 b3 empty", outEmpty, 1);
    nextCycle();
    applyStimulus(0, 1'b1, 1'b1, 1'b1, 32'hA3, 2'd0);
    settle();
    checkOutput("t1 gap busy", busy, 0);
    checkOutput("t1 gap outValid", outValid, 0);
    nextCycle();
    checkOutput("t1 next grant", grantIdx, 0);
    checkOutput("t1 next data", outData, 32'hA3);
    nextCycle();
    clearAll();

    // reset pulse so source 0 leads, then all four contend with 2-beat packets
    rst_n = 1'b0;
    #3 rst_n = 1'b1;
    order  = '{0, 1, 2, 3, 0};
    beat   = '{default: 0};
    pkt    = 0;
    curSrc = 0;
    cyc    = 0;
    nextCycle();
    while (pkt < 5 && cyc < 60) begin
      for (int i = 0; i < NS; i++) begin
        applyStimulus(i, 1'b1, beat[i] == 0, beat[i] == 1, 32'(32'hB000 + 256 * i + beat[i]), 2'd0);
      end
      settle();
      if (outValid && outRdy) begin
        if (outSop) begin
          curSrc = order[pkt];
          checkOutput("rr grant", grantIdx, curSrc);
          checkOutput("rr beat1 data", outData, 32'(32'hB000 + 256 * curSrc));
        end else begin
          checkOutput("rr beat2 data", outData, 32'(32'hB000 + 256 * curSrc + 1));
        end
        if (outEop) pkt++;
      end
      for (int i = 0; i < NS; i++) begin
        if (srcValid[i] && srcRdy[i]) beat[i] = (beat[i] + 1) % 2;
      end
      nextCycle();
      cyc++;
    end
    checkOutput("rr packets done", pkt, 5);
    clearAll();

    // source 2, 5 beats, long downstream backpressure must not trip the watchdog
    applyStimulus(2, 1'b1, 1'b1, 1'b0, 32'hC0, 2'd0);
    outRdy = 1'b1;
    nextCycle();
    b   = 0;
    cyc = 0;
    while (b < 5 && cyc < 40) begin
      applyStimulus(2, 1'b1, b == 0, b == 4, 32'(32'hC0 + b), 2'd0);
      outRdy = (cyc >= 4 && cyc < 16) ? 1'b0 : ((cyc % 2) == 0);
      settle();
      checkOutput("bp grant", grantIdx, 2);
      checkOutput("bp data", outData, 32'(32'hC0 + b));
      checkOutput("bp timeout", timeoutIndc, 0);
      if (outRdy) b++;
      nextCycle();
      cyc++;
    end
    checkOutput("bp beats", b, 5);
    outRdy = 1'b1;
    clearAll();
    settle();
    checkOutput("bp idle busy", busy, 0);

    // source 1 stalls after sop: forced close after 8 idle cycles, then flush
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'h10, 2'd0);
    nextCycle();
    checkOutput("to grant", grantIdx, 1);
    checkOutput("to sop data", outData, 32'h10);
    nextCycle();
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0);
    for (int k = 0; k < TO; k++) begin
      settle();
      checkOutput("to stall outValid", outValid, 0);
      checkOutput("to stall timeout", timeoutIndc, 0);
      nextCycle();
    end
    checkOutput("to close valid", outValid, 1);
    checkOutput("to close eop", outEop, 1);
    checkOutput("to close sop", outSop, 0);
    checkOutput("to close data", outData, 0);
    checkOutput("to close pulse", timeoutIndc, 1);
    checkOutput("to close srcRdy1", srcRdy[1], 0);
    nextCycle();
    applyStimulus(1, 1'b1, 1'b0, 1'b0, 32'h11, 2'd0);
    applyStimulus(3, 1'b1, 1'b1, 1'b1, 32'h30, 2'd2);
    settle();
    checkOutput("fl idle busy", busy, 0);
    checkOutput("fl srcRdy1", srcRdy[1], 1);
    checkOutput("fl srcRdy3", srcRdy[3], 0);
    checkOutput("fl outValid", outValid, 0);
    checkOutput("fl no pulse", timeoutIndc, 0);
    nextCycle();
    applyStimulus(1, 1'b1, 1'b0, 1'b1, 32'h12, 2'd0);
    applyStimulus(3, 1'b1, 1'b1, 1'b1, 32'h30, 2'd2);
    settle();
    checkOutput("fl grant3", grantIdx, 3);
    checkOutput("fl src3 data", outData, 32'h30);
    checkOutput("fl src3 empty", outEmpty, 2);
    checkOutput("fl srcRdy1 eop", srcRdy[1], 1);
    checkOutput("fl srcRdy3", srcRdy[3], 1);
    nextCycle();
    clearAll();
    applyStimulus(1, 1'b1, 1'b1, 1'b1, 32'h1A, 2'd0);
    settle();
    checkOutput("fl cleared srcRdy1", srcRdy[1], 0);
    checkOutput("fl cleared busy", busy, 0);
    nextCycle();
    checkOutput("fl regrant1", grantIdx, 1);
    checkOutput("fl regrant sop", outSop, 1);
    checkOutput("fl regrant data", outData, 32'h1A);
    nextCycle();
    clearAll();

    // reset in the middle of a source 0 packet
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'hD0, 2'd0);
    nextCycle();
    checkOutput("rs grant", grantIdx, 0);
    checkOutput("rs busy", busy, 1);
    nextCycle();
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 32'hD1, 2'd0);
    settle();
    checkOutput("rs mid valid", outValid, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rs outValid", outValid, 0);
    checkOutput("rs busy low", busy, 0);
    checkOutput("rs srcRdy", srcRdy, 0);
    checkOutput("rs grantIdx", grantIdx, 0);
    checkOutput("rs outData", outData, 0);
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'hE0, 2'd0);
    applyStimulus(2, 1'b1, 1'b1, 1'b0, 32'hE2, 2'd0);
    #1 rst_n = 1'b1;
    nextCycle();
    checkOutput("rs first grant", grantIdx, 0);
    checkOutput("rs first data", outData, 32'hE0);

    // valid returns exactly when the stall count reaches its limit: no close
    nextCycle();
    clearAll();
    for (int k = 0; k < TO - 1; k++) begin
      settle();
      checkOutput("cx stall outValid", outValid, 0);
      checkOutput("cx stall busy", busy, 1);
      nextCycle();
    end
    applyStimulus(0, 1'b1, 1'b0, 1'b1, 32'hE1, 2'd3);
    settle();
    checkOutput("cx late valid", outValid, 1);
    checkOutput("cx late eop", outEop, 1);
    checkOutput("cx late data", outData, 32'hE1);
    checkOutput("cx late empty", outEmpty, 3);
    checkOutput("cx no timeout", timeoutIndc, 0);
    nextCycle();
    clearAll();
    settle();
    checkOutput("cx idle busy", busy, 0);
    checkOutput("cx no flush", srcRdy[0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
